// File: rtl/dmem_if.sv
// Memory-stage <-> data-memory responder bus: word address, store strobe/data,
// registered read data, readiness and store counter.
interface dmem_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address_dmem;
  logic                  wren;
  logic [DATA_WIDTH-1:0] d_dmem;
  logic [DATA_WIDTH-1:0] q_dmem;
  logic                  ready;
  logic [15:0]           store_count;

  // Handshake: an access is accepted on every rising edge where ready=1.
  // wren=1 stores d_dmem at address_dmem, wren=0 reads it; q_dmem carries the
  // result one edge later. While ready=0 all requests are dropped.
  modport master (
    output address_dmem, wren, d_dmem,
    input  q_dmem, ready, store_count
  );

  modport slave (
    input  address_dmem, wren, d_dmem,
    output q_dmem, ready, store_count
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory for the memory stage: zero-fills itself after reset,
// then serves 1-cycle reads and write-first stores, counting accepted stores.
module dmem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic  clock,
  input  logic  reset,
  dmem_if.slave bus,
  output logic  fsm_state
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [15:0]           COUNT_MAX = 16'hFFFF;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clear_ptr;
  logic [DATA_WIDTH-1:0] q_reg;
  logic                  ready_reg;
  logic [15:0]           count_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // One write port shared by the zero-fill sweep and user stores; reset blocks both.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clear_ptr;
    mem_wdata = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (bus.wren) begin
        mem_we    = 1'b1;
        mem_waddr = bus.address_dmem;
        mem_wdata = bus.d_dmem;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLEAR;
      clear_ptr <= '0;
      q_reg     <= '0;
      ready_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clear_ptr <= clear_ptr + 1'b1;
          q_reg     <= '0;
          if (clear_ptr == LAST_ADDR) begin
            state     <= READY;
            ready_reg <= 1'b1;
          end
        end
        READY: begin
          if (bus.wren) begin
            // Write-first: the stored word is returned, never the old one.
            q_reg <= bus.d_dmem;
            if (count_reg != COUNT_MAX) begin
              count_reg <= count_reg + 16'd1;
            end
          end else begin
            q_reg <= mem[bus.address_dmem];
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  assign bus.q_dmem      = q_reg;
  assign bus.ready       = ready_reg;
  assign bus.store_count = count_reg;
  assign fsm_state       = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: zero-fill timing, write-first
// stores, read-back, counter saturation and reset in both states.
module tb_dmem_responder;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic clock;
  logic reset;
  logic fsm_state;

  dmem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.wren         = 1'b0;
    bus.address_dmem = '0;
    bus.d_dmem       = '0;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    bus.address_dmem = a;
    bus.d_dmem       = d;
    bus.wren         = 1'b1;
    tick();
    check(tag, bus.q_dmem, d);
    bus.wren = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    bus.address_dmem = a;
    bus.wren         = 1'b0;
    tick();
    check(tag, bus.q_dmem, exp);
  endtask

  // Runs a full zero-fill from reset release, checking ready timing and q=0.
  task automatic run_clear(input string tag, input bit poke_store);
    int early_ready;
    int nonzero_q;
    early_ready = 0;
    nonzero_q   = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (poke_store && k <= 100) begin
        bus.wren         = 1'b1;
        bus.address_dmem = 12'h005;
        bus.d_dmem       = 32'h0000AAAA;
      end else begin
        drive_idle();
      end
      tick();
      if (k < DEPTH && bus.ready !== 1'b0) early_ready++;
      if (bus.q_dmem !== '0) nonzero_q++;
    end
    check({tag, "_early_ready"}, DW'(early_ready), '0);
    check({tag, "_q_zero"}, DW'(nonzero_q), '0);
    check({tag, "_ready_at_depth"}, DW'(bus.ready), 32'd1);
    check({tag, "_count_zero"}, DW'(bus.store_count), '0);
  endtask

  logic [AW-1:0] vec_addr [8];
  logic [DW-1:0] vec_data [8];

  initial begin
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    check("rst_ready", DW'(bus.ready), '0);
    check("rst_q", bus.q_dmem, '0);
    check("rst_count", DW'(bus.store_count), '0);

    // First fill, with a store attempt that must be ignored
    reset = 1'b0;
    run_clear("clear1", 1'b1);

    do_read(12'h005, 32'h0, "clear_store_ignored");
    check("count_after_ignored", DW'(bus.store_count), '0);

    do_store(12'h010, 32'hDEADBEEF, "wf_010");
    do_read(12'h010, 32'hDEADBEEF, "rd_010");
    check("count_1", DW'(bus.store_count), 32'd1);

    do_store(12'h0FF, 32'h12345678, "wf_0ff");
    do_read(12'h0FF, 32'h12345678, "rd_0ff");
    check("count_2", DW'(bus.store_count), 32'd2);

    // Boundary addresses and aliasing
    do_read(12'h000, 32'h0, "rd_000_clear");
    do_read(12'hFFF, 32'h0, "rd_fff_clear");
    do_store(12'hFFF, 32'hCAFEF00D, "wf_fff");
    do_read(12'h000, 32'h0, "rd_000_no_alias");
    do_read(12'hFFF, 32'hCAFEF00D, "rd_fff");
    do_read(12'h010, 32'hDEADBEEF, "rd_010_kept");

    // Batch stores then read back against the expected queue
    vec_addr = '{12'h001, 12'h002, 12'h7FF, 12'h800, 12'h123, 12'hABC, 12'h3C3, 12'hFFE};
    vec_data = '{32'h00000001, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A,
                 32'h0BADF00D, 32'h80000000, 32'h7FFFFFFF, 32'h13579BDF};
    for (int i = 0; i < 8; i++) begin
      do_store(vec_addr[i], vec_data[i], "wf_batch");
      exp_q.push_back(vec_data[i]);
    end
    for (int i = 0; i < 8; i++) begin
      do_read(vec_addr[i], exp_q.pop_front(), "rd_batch");
    end
    check("count_batch", DW'(bus.store_count), 32'd11);

    // Reset in READY with a simultaneous store: the store must not happen
    bus.wren         = 1'b1;
    bus.address_dmem = 12'h020;
    bus.d_dmem       = 32'h11111111;
    reset            = 1'b1;
    tick();
    check("rst_ready_mid", DW'(bus.ready), '0);
    check("rst_count_mid", DW'(bus.store_count), '0);
    check("rst_q_mid", bus.q_dmem, '0);
    reset = 1'b0;
    drive_idle();

    // Reset again part-way through the fill: must restart from address 0
    for (int k = 0; k < 50; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_clear("clear2", 1'b0);

    do_read(12'h010, 32'h0, "rd_010_after_reset");
    do_read(12'h020, 32'h0, "rd_020_reset_store");
    do_read(12'hFFF, 32'h0, "rd_fff_after_reset");

    // Counter saturation: 65537 back-to-back stores
    bus.wren = 1'b1;
    for (int i = 0; i <= 65536; i++) begin
      bus.address_dmem = AW'(i);
      bus.d_dmem       = DW'(i);
      tick();
      if (i == 65533) check("count_fffe", DW'(bus.store_count), 32'h0000FFFE);
      if (i == 65534) check("count_ffff", DW'(bus.store_count), 32'h0000FFFF);
    end
    bus.wren = 1'b0;
    check("count_sat", DW'(bus.store_count), 32'h0000FFFF);
    do_read(12'h000, 32'h00010000, "rd_last_store");
    do_read(12'hFFF, 32'h0000FFFF, "rd_fff_sat");
    check("count_sat_hold", DW'(bus.store_count), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: word address width, which matches address_dmem from the memory stage.
REQ-002 Parameter DATA_WIDTH, default 32: word width.
REQ-003 Parameter DEPTH, default 4096: number of words, which SHALL equal 2^ADDR_WIDTH.
REQ-004 clock  input  1: single clock; all state changes on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 address_dmem  input  ADDR_WIDTH: word address, from the memory stage.
REQ-007 wren  input  1: store request, from the memory stage; 1 = write d_dmem to address_dmem.
REQ-008 d_dmem  input  DATA_WIDTH: store data.
REQ-009 q_dmem  output  DATA_WIDTH: registered read data, returned to the memory stage.
REQ-010 ready  output  1: 1 = memory initialised and accepting accesses.
REQ-011 store_count  output  16: number of accepted stores, saturating.

Function
REQ-012 Two-state FSM SHALL be implemented: CLEAR and READY.
REQ-013 CLEAR SHALL write 0 to mem[clear_ptr] every cycle and increment clear_ptr.
- The first cycle with reset low writes address 0.
- Cycle k writes address k.
REQ-014 CLEAR SHALL transition to READY on the edge that writes address DEPTH-1, so ready=1 exactly DEPTH cycles after reset deasserts.
REQ-015 In CLEAR, wren, address_dmem and d_dmem SHALL be ignored: no store, no count change, and q_dmem held at 0.
REQ-016 In READY with wren=0, each edge SHALL load q_dmem <= mem[address_dmem], giving 1-cycle read latency.
REQ-017 In READY with wren=1, each edge SHALL perform both of the following:
- mem[address_dmem] <= d_dmem;
- q_dmem <= d_dmem (write-first read-during-write; new data returned, never old).
REQ-018 A store to address A followed next cycle by a read of A SHALL return the stored value.
REQ-019 store_count SHALL increment by 1 on each accepted store (READY and wren=1) and hold at 16'hFFFF once reached; no wrap-around.
REQ-020 READY SHALL persist until reset; there is no other exit.
REQ-021 Address decode SHALL be exact over 0..DEPTH-1, with no aliasing and no out-of-range handling required.
REQ-022 Memory contents SHALL be defined only after CLEAR completes; nothing reads mem before then.

Reset
REQ-023 While reset=1, each edge SHALL set state=CLEAR, clear_ptr=0, q_dmem=0, ready=0, store_count=0.
REQ-024 Reset asserted mid-operation, in either state, SHALL abort the current activity and restart CLEAR from address 0; all prior contents are lost.
REQ-025 Reset SHALL take priority over a simultaneous wren; no store occurs on a reset edge.
REQ-026 Outputs SHALL be undefined only before the first reset edge; the bench SHALL apply reset of at least 1 cycle at start.

Verification
REQ-027 Reset 2 cycles, then release -> ready=0 and q_dmem=0 for exactly 4096 cycles; ready=1 from cycle 4096 onward; store_count=0.
REQ-028 After ready, store 32'hDEADBEEF at 12'h010, then read 12'h010 next cycle -> q_dmem=32'hDEADBEEF one edge after the read address is presented; store_count=1.
REQ-029 Store 32'h12345678 at 12'h0FF -> q_dmem=32'h12345678 on that same edge (write-first); subsequent read of 12'h0FF returns the same value.
REQ-030 During CLEAR, wren=1 at 12'h005 with data 32'h0000AAAA -> ignored; after ready, read 12'h005 -> 0, store_count=0.
REQ-031 After ready, 65537 consecutive stores -> store_count=16'hFFFF with no wrap; the last store is still written to memory.
REQ-032 After several stores (e.g. 12'h010=32'hDEADBEEF), assert reset for 1 cycle in READY -> ready=0, store_count=0; after 4096 cycles ready=1 and read 12'h010 -> 0.
